// File: rtl/pool_window_scheduler.sv
// pool_window_scheduler
// ---------------------------------------------------------------------------
// Max-pooling controller. Walks every KxK pooling window of a square feature
// map in raster order, fetches the window one element per cycle from an
// external single-port RAM (1-cycle read latency), reduces it to its signed
// maximum and writes the result to an output RAM through a ready/enable port.
//
// Ports
//   clock     in   single clock, rising edge
//   nreset    in   asynchronous active-low reset
//   start     in   begin a pass (sampled only while idle)
//   busy      out  pass in progress
//   done      out  pass finished; held until next accepted start or reset
//   rd_en     out  input RAM read strobe
//   rd_addr   out  input RAM address, row-major r*SIZEOUTCONV+c
//   rd_data   in   signed read data, valid one cycle after rd_en
//   wr_en     out  output write request
//   wr_addr   out  output address, row-major orow*OUT+ocol
//   wr_data   out  signed window maximum
//   wr_ready  in   sink accepts the write when wr_en && wr_ready
// ---------------------------------------------------------------------------
module pool_window_scheduler #(
    parameter int SIZEOUTCONV = 64,
    parameter int SIZEPOOLING = 2,
    parameter int STRIDE      = 1,
    parameter int WIDTH_BIT   = 16,
    localparam int OUT = (SIZEOUTCONV - SIZEPOOLING) / STRIDE + 1,
    localparam int IAW = (SIZEOUTCONV * SIZEOUTCONV > 1) ? $clog2(SIZEOUTCONV * SIZEOUTCONV) : 1,
    localparam int OAW = (OUT * OUT > 1) ? $clog2(OUT * OUT) : 1
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [IAW-1:0]       rd_addr,
    input  logic [WIDTH_BIT-1:0] rd_data,
    output logic                 wr_en,
    output logic [OAW-1:0]       wr_addr,
    output logic [WIDTH_BIT-1:0] wr_data,
    input  logic                 wr_ready
);

    // Counter width: large enough for any row/column index of the input map.
    localparam int CW = $clog2(SIZEOUTCONV + 1);

    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] KM1_C  = CW'(SIZEPOOLING - 1);
    localparam logic [CW-1:0] OM1_C  = CW'(OUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LAST  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Input address of element (ki,kj) of window (orow,ocol). Every term is
    // widened to IAW before multiplying so no partial product is truncated.
    function automatic logic [IAW-1:0] rd_addr_f(
        input logic [CW-1:0] orow,
        input logic [CW-1:0] ocol,
        input logic [CW-1:0] ki,
        input logic [CW-1:0] kj
    );
        logic [IAW-1:0] row_s;
        logic [IAW-1:0] col_s;
        row_s = IAW'(orow) * IAW'(STRIDE) + IAW'(ki);
        col_s = IAW'(ocol) * IAW'(STRIDE) + IAW'(kj);
        return row_s * IAW'(SIZEOUTCONV) + col_s;
    endfunction

    // Output address of window (orow,ocol), computed at full OAW width.
    function automatic logic [OAW-1:0] wr_addr_f(
        input logic [CW-1:0] orow,
        input logic [CW-1:0] ocol
    );
        return OAW'(orow) * OAW'(OUT) + OAW'(ocol);
    endfunction

    state_t                 state_r, state_s;
    logic [CW-1:0]          orow_r, orow_s;
    logic [CW-1:0]          ocol_r, ocol_s;
    logic [CW-1:0]          ki_r, ki_s;
    logic [CW-1:0]          kj_r, kj_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   rd_en_r, rd_en_s;
    logic                   rd_first_r, rd_first_s;
    logic [IAW-1:0]         rd_addr_r, rd_addr_s;
    logic                   wr_en_r, wr_en_s;
    logic [OAW-1:0]         wr_addr_r, wr_addr_s;
    logic [WIDTH_BIT-1:0]   wr_data_r, wr_data_s;

    // Read-return pipeline: rd_data is qualified by the delayed strobe.
    logic                   rd_vld_r;
    logic                   rd_first_d_r;
    logic [WIDTH_BIT-1:0]   acc_r, acc_s;

    logic                   last_kernel_s;
    logic                   last_win_s;

    assign last_kernel_s = (ki_r == KM1_C) && (kj_r == KM1_C);
    assign last_win_s    = (orow_r == OM1_C) && (ocol_r == OM1_C);

    // Running maximum: first element of a window loads, later ones keep the larger (ties keep acc).
    always_comb begin
        acc_s = acc_r;
        if (rd_vld_r) begin
            if (rd_first_d_r) begin
                acc_s = rd_data;
            end else if ($signed(rd_data) > $signed(acc_r)) begin
                acc_s = rd_data;
            end else begin
                acc_s = acc_r;
            end
        end else begin
            acc_s = acc_r;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s    = state_r;
        orow_s     = orow_r;
        ocol_s     = ocol_r;
        ki_s       = ki_r;
        kj_s       = kj_r;
        busy_s     = busy_r;
        done_s     = done_r;
        rd_en_s    = 1'b0;
        rd_first_s = 1'b0;
        rd_addr_s  = rd_addr_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = wr_addr_r;
        wr_data_s  = wr_data_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_FETCH;
                    busy_s     = 1'b1;
                    done_s     = 1'b0;
                    orow_s     = ZERO_C;
                    ocol_s     = ZERO_C;
                    ki_s       = ZERO_C;
                    kj_s       = ZERO_C;
                    rd_en_s    = 1'b1;
                    rd_first_s = 1'b1;
                    rd_addr_s  = rd_addr_f(ZERO_C, ZERO_C, ZERO_C, ZERO_C);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_FETCH: begin
                if (last_kernel_s) begin
                    // Final read of the window was issued this cycle.
                    state_s = ST_LAST;
                end else begin
                    if (kj_r == KM1_C) begin
                        kj_s = ZERO_C;
                        ki_s = ki_r + ONE_C;
                    end else begin
                        kj_s = kj_r + ONE_C;
                    end
                    rd_en_s   = 1'b1;
                    rd_addr_s = rd_addr_f(orow_r, ocol_r, ki_s, kj_s);
                end
            end

            ST_LAST: begin
                // acc_s already folds in the final datum returning this cycle.
                state_s   = ST_WRITE;
                wr_en_s   = 1'b1;
                wr_addr_s = wr_addr_f(orow_r, ocol_r);
                wr_data_s = acc_s;
            end

            ST_WRITE: begin
                if (wr_ready) begin
                    if (last_win_s) begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        ki_s = ZERO_C;
                        kj_s = ZERO_C;
                        if (ocol_r == OM1_C) begin
                            ocol_s = ZERO_C;
                            orow_s = orow_r + ONE_C;
                        end else begin
                            ocol_s = ocol_r + ONE_C;
                        end
                        state_s    = ST_FETCH;
                        rd_en_s    = 1'b1;
                        rd_first_s = 1'b1;
                        rd_addr_s  = rd_addr_f(orow_s, ocol_s, ZERO_C, ZERO_C);
                    end
                end else begin
                    // Stalled: hold the request, address and data unchanged.
                    wr_en_s = 1'b1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Control state, window counters and registered outputs.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r    <= ST_IDLE;
            orow_r     <= ZERO_C;
            ocol_r     <= ZERO_C;
            ki_r       <= ZERO_C;
            kj_r       <= ZERO_C;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_en_r    <= 1'b0;
            rd_first_r <= 1'b0;
            rd_addr_r  <= {IAW{1'b0}};
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {OAW{1'b0}};
            wr_data_r  <= {WIDTH_BIT{1'b0}};
        end else begin
            state_r    <= state_s;
            orow_r     <= orow_s;
            ocol_r     <= ocol_s;
            ki_r       <= ki_s;
            kj_r       <= kj_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            rd_en_r    <= rd_en_s;
            rd_first_r <= rd_first_s;
            rd_addr_r  <= rd_addr_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
        end
    end

    // Read-return qualifiers and the window accumulator.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rd_vld_r     <= 1'b0;
            rd_first_d_r <= 1'b0;
            acc_r        <= {WIDTH_BIT{1'b0}};
        end else begin
            rd_vld_r     <= rd_en_r;
            rd_first_d_r <= rd_first_r;
            acc_r        <= acc_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_en   = rd_en_r;
    assign rd_addr = rd_addr_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

endmodule
